// File: rtl/nn_ctrl_pkg.sv
// Shared types and sizing constants for the classifier frame controller.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    EMIT
  } seq_state_t;

  localparam int unsigned DEF_IMG_W   = 28;
  localparam int unsigned DEF_IMG_H   = 28;
  localparam int unsigned DEF_X0      = 306;
  localparam int unsigned DEF_Y0      = 226;
  localparam int unsigned DEF_TIMEOUT = 4096;

  // Largest line length / frame height the position counters must span.
  localparam int unsigned LINE_MAX    = 2048;
  localparam int unsigned FRAME_MAX   = 2048;
  localparam int unsigned COL_W       = $clog2(LINE_MAX);
  localparam int unsigned ROW_W       = $clog2(FRAME_MAX);

  localparam int unsigned CLASS_W     = 4;
  localparam int unsigned DROP_W      = 8;

endpackage

// File: rtl/sync_edge_det.sv
// Single-register edge detector for a camera sync line.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic d_r;

  // Hold the previous sample of the line.
  always_ff @(posedge clk) begin
    if (rst) d_r <= 1'b0;
    else     d_r <= d;
  end

  assign level = d_r;
  assign rise  = d & ~d_r;
  assign fall  = ~d & d_r;

endmodule

// File: rtl/inference_sequencer.sv
// Frame-level controller: opens the crop window on the pixel stream, follows the
// layer done chain and publishes one class result per processed frame.
module inference_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned X0         = DEF_X0,
  parameter int unsigned Y0         = DEF_Y0,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  VSYNC,
  input  logic                  HSYNC,
  output logic                  pix_en,
  output logic                  freeze,
  output logic                  capture_done,
  input  logic [NUM_LAYERS-2:0] layer_done,
  input  logic [CLASS_W-1:0]    final_class,
  output logic [CLASS_W-1:0]    result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [DROP_W-1:0]     frames_dropped
);

  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
  localparam int unsigned PIX_W     = $clog2(FRAME_PIX + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_LAYERS);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);

  localparam logic [COL_W-1:0] COL_LO   = COL_W'(X0);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(X0 + IMG_W);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(Y0);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(Y0 + IMG_H);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX);
  localparam logic [PIX_W-1:0] PIX_PEN  = PIX_W'(FRAME_PIX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYERS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_t state, state_nxt;

  logic vs_level, vs_rise, vs_fall;
  logic hs_level, hs_rise, hs_fall;
  logic unused_vs;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [PIX_W-1:0]      pix_cnt;
  logic [IDX_W-1:0]      idx;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [NUM_LAYERS-2:0] ld_r, ld_rise;
  logic                  adv, timeout_hit, in_window;

  sync_edge_det u_vsync (
    .clk   (clk),
    .rst   (rst),
    .d     (VSYNC),
    .level (vs_level),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  sync_edge_det u_hsync (
    .clk   (clk),
    .rst   (rst),
    .d     (HSYNC),
    .level (hs_level),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  assign unused_vs = vs_level ^ vs_fall;
  assign ld_rise   = layer_done & ~ld_r;
  assign in_window = (col >= COL_LO) && (col < COL_HI) && (row >= ROW_LO) && (row < ROW_HI);

  // Stage advance: only a rising edge on the bit of the stage being waited on counts.
  always_comb begin
    adv = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS - 1; i++) begin
      if (state == DRAIN && idx == IDX_W'(i) && ld_rise[i]) adv = 1'b1;
    end
  end

  assign timeout_hit = (state == DRAIN) && (idx != IDX_LAST) && !adv && (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise) state_nxt = CAPTURE;
      CAPTURE: if (pix_cnt == PIX_LAST) state_nxt = DRAIN;
      DRAIN: begin
        if (idx == IDX_LAST) state_nxt = EMIT;
        else if (timeout_hit) state_nxt = IDLE;
      end
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    capture_done = (state == CAPTURE) && (pix_cnt == PIX_LAST);
    result_valid = (state == EMIT);
    busy         = (state != IDLE);
  end

  // Pixel position and accepted-pixel counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      pix_cnt <= '0;
    end else begin
      if (vs_rise) begin
        col <= '0;
        row <= '0;
      end else begin
        if (hs_rise)       col <= '0;
        else if (hs_level) col <= col + 1'b1;
        if (hs_fall)       row <= row + 1'b1;
      end
      // A frame whose last pixel coincides with the next VSYNC rise still completes.
      if (vs_rise && !(pix_en && pix_cnt == PIX_PEN)) pix_cnt <= '0;
      else if (pix_en)                                pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Registered crop gate.
  always_ff @(posedge clk) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= (state == CAPTURE) && hs_level && in_window && !vs_rise && (pix_cnt != PIX_LAST);
  end

  assign freeze = ~pix_en;

  // Done-chain index, per-stage timeout timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_r        <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ld_r <= layer_done;
      if (state != DRAIN) begin
        idx     <= '0;
        tmo_cnt <= '0;
      end else if (adv) begin
        idx     <= idx + 1'b1;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Result latch and saturating dropped-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      result         <= '0;
      frames_dropped <= '0;
    end else begin
      if (state == DRAIN && idx == IDX_LAST) result <= final_class;
      if (vs_rise && state != IDLE && frames_dropped != '1)
        frames_dropped <= frames_dropped + 1'b1;
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer using a reduced crop geometry.
module tb_inference_sequencer;

  localparam int NL  = 3;
  localparam int IW  = 6;
  localparam int IH  = 5;
  localparam int CX  = 9;
  localparam int CY  = 4;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          VSYNC = 1'b0;
  logic          HSYNC = 1'b0;
  logic [NL-2:0] layer_done = '0;
  logic [3:0]    final_class = '0;
  logic          pix_en, freeze, capture_done, result_valid, busy, timeout_err;
  logic [3:0]    result;
  logic [7:0]    frames_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  int g_step = 0;
  int g_pe_cnt, g_misplaced, g_freeze_bad, g_cd_cnt, g_cd_step, g_last_pe, g_rv_cnt, g_rv_step;
  bit e1 = 1'b0;
  bit e2 = 1'b0;

  always #5 clk = ~clk;

  inference_sequencer #(
    .NUM_LAYERS (NL),
    .IMG_W      (IW),
    .IMG_H      (IH),
    .X0         (CX),
    .Y0         (CY),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .VSYNC          (VSYNC),
    .HSYNC          (HSYNC),
    .pix_en         (pix_en),
    .freeze         (freeze),
    .capture_done   (capture_done),
    .layer_done     (layer_done),
    .final_class    (final_class),
    .result         (result),
    .result_valid   (result_valid),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .frames_dropped (frames_dropped)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    g_pe_cnt = 0; g_misplaced = 0; g_freeze_bad = 0; g_cd_cnt = 0;
    g_cd_step = -1; g_last_pe = -1; g_rv_cnt = 0; g_rv_step = -1;
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next inputs.
  // exp_pe is the model's pix_en for the pixel driven now (appears two cycles later).
  task automatic step(input bit vs, input bit hs, input logic [NL-2:0] ld, input bit exp_pe);
    @(negedge clk);
    g_step++;
    if (pix_en !== e2) g_misplaced++;
    if (freeze !== ~e2) g_freeze_bad++;
    if (pix_en === 1'b1) begin g_pe_cnt++; g_last_pe = g_step; end
    if (capture_done === 1'b1) begin g_cd_cnt++; g_cd_step = g_step; end
    if (result_valid === 1'b1) begin g_rv_cnt++; g_rv_step = g_step; end
    e2 = e1;
    e1 = exp_pe;
    VSYNC = vs;
    HSYNC = hs;
    layer_done = ld;
  endtask

  // VSYNC pulse then n_lines random-width lines; model marks crop-window pixels.
  task automatic drive_frame(input int n_lines, input bit capturing);
    int lw, bl;
    lw = $urandom_range(CX + IW + 6, CX + IW + 1);
    bl = $urandom_range(5, 2);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int r = 0; r < n_lines; r++) begin
      for (int c = 0; c < lw; c++)
        step(1'b0, 1'b1, '0, capturing && r >= CY && r < CY + IH && c >= CX && c < CX + IW);
      for (int b = 0; b < bl; b++) step(1'b0, 1'b0, '0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (pix_en !== 1'b0) begin n_fail++; $display("FAIL reset_pix_en: got %b want 0", pix_en); end
    n_tests++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze: got %b want 1", freeze); end
    n_tests++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL reset_capture_done: got %b want 0", capture_done); end
    n_tests++; if (result !== 4'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", result); end
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_tests++; if (frames_dropped !== 8'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", frames_dropped); end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    clear_stats();
    drive_frame($urandom_range(CY + IH + 2, CY + IH), 1'b1);
    n_tests++; if (g_pe_cnt != IW * IH) begin n_fail++; $display("FAIL frame_pix_count: got %0d want %0d", g_pe_cnt, IW * IH); end
    n_tests++; if (g_misplaced != 0) begin n_fail++; $display("FAIL frame_pix_position: got %0d misplaced cycles want 0", g_misplaced); end
    n_tests++; if (g_freeze_bad != 0) begin n_fail++; $display("FAIL frame_freeze: got %0d bad cycles want 0", g_freeze_bad); end
    n_tests++; if (g_cd_cnt != 1) begin n_fail++; $display("FAIL frame_capture_done_count: got %0d want 1", g_cd_cnt); end
    n_tests++; if (g_cd_step != g_last_pe + 1) begin n_fail++; $display("FAIL frame_capture_done_latency: got step %0d want %0d", g_cd_step, g_last_pe + 1); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_drain: got %b want 1", busy); end
  endtask

  task automatic test_result();
    logic [3:0] fc;
    int s;
    fc = 4'd7;
    final_class = fc;
    clear_stats();
    repeat ($urandom_range(3, 1)) step(1'b0, 1'b0, 2'b01, 1'b0);
    repeat ($urandom_range(6, 1)) step(1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 2'b10, 1'b0);
    s = g_step;
    repeat (6) step(1'b0, 1'b0, 2'b00, 1'b0);
    n_tests++; if (g_rv_cnt != 1) begin n_fail++; $display("FAIL result_valid_count: got %0d want 1", g_rv_cnt); end
    n_tests++; if (g_rv_step != s + 2) begin n_fail++; $display("FAIL result_valid_latency: got step %0d want %0d", g_rv_step, s + 2); end
    n_tests++; if (result !== fc) begin n_fail++; $display("FAIL result_value: got %0d want %0d", result, fc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL result_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_drop_restart();
    clear_stats();
    drive_frame(CY + 2, 1'b1);
    n_tests++; if (g_pe_cnt != 2 * IW) begin n_fail++; $display("FAIL drop_partial_pix: got %0d want %0d", g_pe_cnt, 2 * IW); end
    clear_stats();
    drive_frame($urandom_range(CY + IH + 1, CY + IH), 1'b1);
    n_tests++; if (frames_dropped !== 8'd1) begin n_fail++; $display("FAIL drop_count: got %0d want 1", frames_dropped); end
    n_tests++; if (g_pe_cnt != IW * IH) begin n_fail++; $display("FAIL drop_restart_pix: got %0d want %0d", g_pe_cnt, IW * IH); end
    n_tests++; if (g_misplaced != 0) begin n_fail++; $display("FAIL drop_restart_position: got %0d misplaced want 0", g_misplaced); end
    n_tests++; if (g_cd_cnt != 1) begin n_fail++; $display("FAIL drop_restart_capture_done: got %0d want 1", g_cd_cnt); end
  endtask

  task automatic test_order();
    logic [3:0] fc;
    logic lvl;
    int s;
    fc = 4'($urandom_range(15, 8));
    lvl = 1'($urandom_range(1, 0));
    final_class = fc;
    clear_stats();
    repeat (2) step(1'b0, 1'b0, 2'b10, 1'b0);
    repeat (4) step(1'b0, 1'b0, 2'b00, 1'b0);
    n_tests++; if (g_rv_cnt != 0) begin n_fail++; $display("FAIL order_early_ignored: got %0d results want 0", g_rv_cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL order_still_drain: got %b want 1", busy); end
    step(1'b0, 1'b0, 2'b01, 1'b0);
    step(1'b0, 1'b0, {1'b0, lvl}, 1'b0);
    step(1'b0, 1'b0, {1'b1, lvl}, 1'b0);
    s = g_step;
    repeat (5) step(1'b0, 1'b0, 2'b00, 1'b0);
    n_tests++; if (g_rv_cnt != 1) begin n_fail++; $display("FAIL order_result_count: got %0d want 1", g_rv_cnt); end
    n_tests++; if (g_rv_step != s + 2) begin n_fail++; $display("FAIL order_result_latency: got step %0d want %0d", g_rv_step, s + 2); end
    n_tests++; if (result !== fc) begin n_fail++; $display("FAIL order_result_value: got %0d want %0d", result, fc); end
  endtask

  task automatic test_edge_vs_timeout();
    int c, s;
    final_class = 4'd3;
    clear_stats();
    drive_frame(CY + IH, 1'b1);
    c = g_cd_step;
    n_tests++;
    if (g_cd_cnt != 1) begin
      n_fail++; $display("FAIL evt_capture_done: got %0d want 1", g_cd_cnt);
    end else begin
      while (g_step < c + TMO - 1) step(1'b0, 1'b0, 2'b00, 1'b0);
      step(1'b0, 1'b0, 2'b01, 1'b0);
      step(1'b0, 1'b0, 2'b00, 1'b0);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL evt_edge_wins_busy: got %b want 1", busy); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL evt_edge_wins_err: got %b want 0", timeout_err); end
      step(1'b0, 1'b0, 2'b10, 1'b0);
      s = g_step;
      repeat (4) step(1'b0, 1'b0, 2'b00, 1'b0);
      n_tests++; if (g_rv_step != s + 2) begin n_fail++; $display("FAIL evt_result_latency: got step %0d want %0d", g_rv_step, s + 2); end
      n_tests++; if (result !== 4'd3) begin n_fail++; $display("FAIL evt_result_value: got %0d want 3", result); end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] prev;
    int c, fall;
    prev = result;
    final_class = ~prev;
    clear_stats();
    drive_frame(CY + IH, 1'b1);
    c = g_cd_step;
    fall = -1;
    for (int i = 0; i < TMO + 50; i++) begin
      step(1'b0, 1'b0, 2'b00, 1'b0);
      if (busy === 1'b0) begin fall = g_step; break; end
    end
    n_tests++; if (fall != c + TMO + 1) begin n_fail++; $display("FAIL timeout_exit_step: got %0d want %0d", fall, c + TMO + 1); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    n_tests++; if (g_rv_cnt != 0) begin n_fail++; $display("FAIL timeout_no_result_valid: got %0d want 0", g_rv_cnt); end
    n_tests++; if (result !== prev) begin n_fail++; $display("FAIL timeout_result_kept: got %0d want %0d", result, prev); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    drive_frame(CY + IH, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout_err: got %b want 0", timeout_err); end
    n_tests++; if (frames_dropped !== 8'd0) begin n_fail++; $display("FAIL rstmid_dropped: got %0d want 0", frames_dropped); end
    n_tests++; if (result !== 4'd0) begin n_fail++; $display("FAIL rstmid_result: got %0d want 0", result); end
    n_tests++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL rstmid_freeze: got %b want 1", freeze); end
    rst = 1'b0;
    clear_stats();
    drive_frame(CY + IH, 1'b1);
    n_tests++; if (g_pe_cnt != IW * IH) begin n_fail++; $display("FAIL rstmid_next_frame_pix: got %0d want %0d", g_pe_cnt, IW * IH); end
    n_tests++; if (g_cd_cnt != 1) begin n_fail++; $display("FAIL rstmid_next_frame_done: got %0d want 1", g_cd_cnt); end
  endtask

  task automatic test_saturation();
    int rises_busy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    rises_busy = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      rises_busy++;
      if (k == 100) begin
        n_tests++;
        if (frames_dropped !== 8'((rises_busy > 255) ? 255 : rises_busy)) begin
          n_fail++; $display("FAIL sat_mid_count: got %0d want %0d", frames_dropped, rises_busy);
        end
      end
    end
    step(1'b0, 1'b0, '0, 1'b0);
    n_tests++;
    if (frames_dropped !== 8'((rises_busy > 255) ? 255 : rises_busy)) begin
      n_fail++; $display("FAIL sat_final_count: got %0d want 255", frames_dropped);
    end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy: got %b want 1", busy); end
    n_tests++; if (g_pe_cnt != 0) begin n_fail++; $display("FAIL sat_no_pixels: got %0d want 0", g_pe_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_result();
    test_drop_restart();
    test_order();
    test_edge_vs_timeout();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
